// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with fill count, almost-full/empty flags, sticky error flags,
// synchronous flush, and either registered-read or first-word-fall-through output.
module sync_fifo_fwft #(
   parameter int DEPTH     = 16,
   parameter int BITW      = 16,
   parameter int FWFT      = 0,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     wr_en,
   input  logic [BITW-1:0]          din,
   input  logic                     rd_en,
   output logic [BITW-1:0]          dout,
   output logic                     dout_valid,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow,
   input  logic                     err_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
   localparam logic [PW-1:0] AF_CNT   = PW'(AF_THRESH);
   localparam logic [PW-1:0] AE_CNT   = PW'(AE_THRESH);

   logic [BITW-1:0] mem [DEPTH];
   logic [PW-1:0]   wptr;
   logic [PW-1:0]   rptr;
   logic [PW-1:0]   count_q;
   logic [PW-1:0]   count_d;
   logic            wr_acc;
   logic            rd_acc;
   logic            ovf_q;
   logic            udf_q;
   logic            dout_valid_q;
   logic [BITW-1:0] dout_q;
   logic [BITW-1:0] head;

   // Flags decode the registered count, so they follow each edge's accept/reject.
   assign full         = (count_q == FULL_CNT);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AF_CNT);
   assign almost_empty = (count_q <= AE_CNT);
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

   assign wr_acc = wr_en && !full  && !flush;
   assign rd_acc = rd_en && !empty && !flush;
   assign head   = mem[rptr[AW-1:0]];

   always_comb begin
      // NOTE: default first so every path assigns count_d and no latch is inferred.
      count_d = count_q;
      if (flush) begin
         count_d = '0;
      end else begin
         case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + PW'(1);
            2'b01:   count_d = count_q - PW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr    <= '0;
         rptr    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         if (flush) begin
            wptr <= '0;
            rptr <= '0;
         end else begin
            if (wr_acc) wptr <= wptr + PW'(1);
            if (rd_acc) rptr <= rptr + PW'(1);
         end
         // A new error in the same cycle as err_clr wins.
         if (wr_en && full && !flush)       ovf_q <= 1'b1;
         else if (err_clr)                  ovf_q <= 1'b0;
         if (rd_en && empty && !flush)      udf_q <= 1'b1;
         else if (err_clr)                  udf_q <= 1'b0;
      end
   end

   // NOTE: storage array has no reset; only pointers and count define its contents.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wptr[AW-1:0]] <= din;
   end

   // dout_q is the registered read word (FWFT=0) or the last presented head word (FWFT=1),
   // which lets dout hold its value across flush and drain-to-empty in both modes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         dout_valid_q <= rd_acc;
         if (FWFT != 0) begin
            if (!empty) dout_q <= head;
         end else if (rd_acc) begin
            dout_q <= head;
         end
      end
   end

   assign dout       = ((FWFT != 0) && !empty) ? head : dout_q;
   assign dout_valid = (FWFT != 0) ? !empty : dout_valid_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Scoreboard bench for sync_fifo_fwft: a registered-read instance checked every cycle
// against a reference model, plus a first-word-fall-through instance.
module tb_sync_fifo_fwft;

   localparam int DEPTH = 16;
   localparam int BITW  = 16;

   logic            clk;
   logic            reset;

   logic            flush, wr_en, rd_en, err_clr;
   logic [BITW-1:0] din;
   logic [BITW-1:0] dout;
   logic            dout_valid, full, empty, almost_full, almost_empty, overflow, underflow;
   logic [4:0]      count;

   logic            f_flush, f_wr, f_rd, f_err_clr;
   logic [BITW-1:0] f_din;
   logic [BITW-1:0] f_dout;
   logic            f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
   logic [4:0]      f_count;

   sync_fifo_fwft #(.DEPTH(DEPTH), .BITW(BITW), .FWFT(0), .AF_THRESH(14), .AE_THRESH(2)) u_dut (
      .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
      .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
   );

   sync_fifo_fwft #(.DEPTH(DEPTH), .BITW(BITW), .FWFT(1), .AF_THRESH(14), .AE_THRESH(2)) u_dut_fw (
      .clk(clk), .reset(reset), .flush(f_flush), .wr_en(f_wr), .din(f_din), .rd_en(f_rd),
      .dout(f_dout), .dout_valid(f_valid), .full(f_full), .empty(f_empty),
      .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
      .overflow(f_ovf), .underflow(f_udf), .err_clr(f_err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model of the registered-read instance.
   logic [BITW-1:0] sb [$];
   logic [BITW-1:0] fq [$];
   int              m_count;
   logic            m_ovf, m_udf, m_valid;
   logic [BITW-1:0] m_dout;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      m_count = 0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      m_valid = 1'b0;
      m_dout  = '0;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".count"}, 32'(count), 32'(m_count));
      check({tag, ".full"}, 32'(full), 32'(m_count == DEPTH));
      check({tag, ".empty"}, 32'(empty), 32'(m_count == 0));
      check({tag, ".almost_full"}, 32'(almost_full), 32'(m_count >= 14));
      check({tag, ".almost_empty"}, 32'(almost_empty), 32'(m_count <= 2));
      check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
      check({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
      check({tag, ".dout_valid"}, 32'(dout_valid), 32'(m_valid));
      check({tag, ".dout"}, 32'(dout), 32'(m_dout));
   endtask

   // One clock of stimulus on the registered-read instance; model advances, then outputs compared.
   task automatic cycle(input string tag, input logic wr, input logic [BITW-1:0] d,
                        input logic rd, input logic fl, input logic ec);
      logic wacc, racc, ovf_set, udf_set;
      wr_en = wr; din = d; rd_en = rd; flush = fl; err_clr = ec;
      wacc    = wr && (m_count != DEPTH) && !fl;
      racc    = rd && (m_count != 0) && !fl;
      ovf_set = wr && (m_count == DEPTH) && !fl;
      udf_set = rd && (m_count == 0) && !fl;
      if (fl) begin
         sb.delete();
         m_count = 0;
      end else begin
         if (racc) begin
            m_dout = sb.pop_front();
            m_count--;
         end
         if (wacc) begin
            sb.push_back(d);
            m_count++;
         end
      end
      m_valid = racc;
      if (ovf_set) m_ovf = 1'b1; else if (ec) m_ovf = 1'b0;
      if (udf_set) m_udf = 1'b1; else if (ec) m_udf = 1'b0;
      @(posedge clk);
      #1;
      wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
      check_outputs(tag);
   endtask

   task automatic f_step(input logic wr, input logic [BITW-1:0] d, input logic rd);
      f_wr = wr; f_din = d; f_rd = rd;
      if (rd && fq.size() != 0) void'(fq.pop_front());
      if (wr) fq.push_back(d);
      @(posedge clk);
      #1;
      f_wr = 1'b0; f_rd = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; din = '0;
      f_flush = 1'b0; f_wr = 1'b0; f_rd = 1'b0; f_err_clr = 1'b0; f_din = '0;
      model_reset();
      #1;
      check_outputs("reset");
      check("fw_reset.dout", 32'(f_dout), 32'h0);
      check("fw_reset.valid", 32'(f_valid), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Fill to full, then one rejected write.
      for (int i = 1; i <= 16; i++) cycle("fill", 1'b1, BITW'(i), 1'b0, 1'b0, 1'b0);
      cycle("overflow", 1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);

      // Back-to-back reads, then one rejected read.
      for (int i = 0; i < 16; i++) cycle("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
      cycle("underflow", 1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Simultaneous read/write at mid-level, empty and full.
      cycle("clr1", 1'b0, '0, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 5; i++) cycle("mid_fill", 1'b1, 16'h0200 + BITW'(i), 1'b0, 1'b0, 1'b0);
      cycle("mid_rw", 1'b1, 16'h0206, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cycle("mid_drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
      cycle("empty_rw", 1'b1, 16'h0301, 1'b1, 1'b0, 1'b0);
      for (int i = 2; i <= 16; i++) cycle("refill", 1'b1, 16'h0300 + BITW'(i), 1'b0, 1'b0, 1'b0);
      cycle("full_rw", 1'b1, 16'h03FF, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) cycle("full_drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Flush with a coincident write; error flags must survive.
      for (int i = 1; i <= 7; i++) cycle("pre_flush", 1'b1, 16'h0400 + BITW'(i), 1'b0, 1'b0, 1'b0);
      cycle("flush", 1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b0);
      cycle("post_flush", 1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Interleaved traffic across pointer wrap, then clear errors.
      for (int i = 0; i < 40; i++) cycle("wrap", 1'b1, 16'h0100 + BITW'(i), (i >= 2), 1'b0, 1'b0);
      cycle("wrap_tail", 1'b0, '0, 1'b1, 1'b0, 1'b0);
      cycle("wrap_tail", 1'b0, '0, 1'b1, 1'b0, 1'b0);
      cycle("err_clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);

      // Asynchronous reset in the middle of a burst.
      for (int i = 1; i <= 3; i++) cycle("burst", 1'b1, 16'h0500 + BITW'(i), 1'b0, 1'b0, 1'b0);
      wr_en = 1'b1; din = 16'h0504;
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_outputs("async_reset");
      wr_en = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_outputs("reset_held");

      // First-word-fall-through instance.
      f_step(1'b1, 16'hA5A5, 1'b0);
      check("fw_w1.dout", 32'(f_dout), 32'(fq[0]));
      check("fw_w1.valid", 32'(f_valid), 32'h1);
      check("fw_w1.count", 32'(f_count), 32'(fq.size()));
      f_step(1'b1, 16'h5A5A, 1'b0);
      check("fw_w2.dout", 32'(f_dout), 32'(fq[0]));
      check("fw_w2.count", 32'(f_count), 32'(fq.size()));
      f_step(1'b0, '0, 1'b1);
      check("fw_r1.dout", 32'(f_dout), 32'(fq[0]));
      check("fw_r1.valid", 32'(f_valid), 32'h1);
      f_step(1'b0, '0, 1'b1);
      check("fw_r2.empty", 32'(f_empty), 32'(fq.size() == 0));
      check("fw_r2.valid", 32'(f_valid), 32'h0);
      check("fw_r2.udf", 32'(f_udf), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
